sdram_init_param: RTL

SDRAM_INIT_PARAM -- requirements
Module: sdram_init_param

---
 rtl/sdram_init_param.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_init_param.sv
// SDRAM power-up initialisation sequencer: power-up wait, PRECHARGE-all,
//   REF_CNT x AUTO_REFRESH, MODE_SET, optional extended MODE_SET, then DONE.
// All outputs are registered; re-initialisation restarts at PRECHARGE.
//
// Ports:
//   sclk          single clock, rising edge
//   reset         synchronous active-high reset
//   init_req      re-initialisation request, honoured only once init is done
//   cmd_reg       {CS_n,RAS_n,CAS_n,WE_n}
//   sdram_addr    address bus (A10 high on every non-MODE_SET cycle)
//   sdram_bank    bank address
//   flag_init_end high while initialisation is complete
//
// Build option: define SDRAM_INIT_EMRS_EN to add the extended mode register
// step (MODE_SET with EMODE_VAL on the top bank bit) after the MODE_SET.
module sdram_init_param #(
  parameter int          ADDR_W    = 12,
  parameter int          BA_W      = 2,
  parameter int          T_PWR     = 10000,
  parameter int          T_RP      = 2,
  parameter int          T_RFC     = 7,
  parameter int          T_MRD     = 2,
  parameter int          REF_CNT   = 2,
  parameter logic [11:0] MODE_VAL  = 12'h032,
  parameter logic [11:0] EMODE_VAL = 12'h000
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              init_req,
  output logic [3:0]        cmd_reg,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_bank,
  output logic              flag_init_end
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  localparam int T_MAX0 = (T_PWR > T_RP) ? T_PWR : T_RP;
  localparam int T_MAX1 = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int T_MAX  = (T_MAX0 > T_MAX1) ? T_MAX0 : T_MAX1;
  localparam int CNT_W  = $clog2(T_MAX + 1);
  localparam int RC_W   = $clog2(REF_CNT + 1);

  localparam logic [ADDR_W-1:0] ADDR_A10  = ADDR_W'(1) << 10;
  localparam logic [ADDR_W-1:0] MODE_EXT  = ADDR_W'(MODE_VAL);

  // Reject parameter sets the sequencer cannot honour, including mode
  // values that would not survive zero-extension into the address bus.
  if (ADDR_W < 11 || BA_W < 1 || T_PWR < 1 || T_RP < 1 || T_RFC < 1 ||
      T_MRD < 1 || REF_CNT < 1 ||
      (32'(MODE_VAL) >> ADDR_W) != 0 || (32'(EMODE_VAL) >> ADDR_W) != 0) begin : g_bad_param
    $error("sdram_init_param: illegal parameter set");
  end

`ifdef SDRAM_INIT_EMRS_EN
  localparam logic [ADDR_W-1:0] EMODE_EXT = ADDR_W'(EMODE_VAL);
  localparam logic [BA_W-1:0]   BANK_MSB  = BA_W'(1) << (BA_W - 1);
`endif

  typedef enum logic [2:0] {
    ST_PWR,
    ST_PRE,
    ST_REF,
    ST_MRS,
`ifdef SDRAM_INIT_EMRS_EN
    ST_EMRS,
`endif
    ST_DONE
  } state_t;

  state_t            state, state_nxt;
  // cnt = cycles elapsed since the last command (or since reset release in PWR)
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [RC_W-1:0]   rcnt, rcnt_nxt;
  logic [3:0]        cmd_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [BA_W-1:0]   bank_nxt;

  always_ff @(posedge sclk) begin
    if (reset) begin
      state         <= ST_PWR;
      cnt           <= '0;
      rcnt          <= '0;
      cmd_reg       <= CMD_NOP;
      sdram_addr    <= '0;
      sdram_bank    <= '0;
      flag_init_end <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      rcnt          <= rcnt_nxt;
      cmd_reg       <= cmd_nxt;
      sdram_addr    <= addr_nxt;
      sdram_bank    <= bank_nxt;
      flag_init_end <= (state_nxt == ST_DONE);
    end
  end

  // Each wait compares against its limit before incrementing, so cnt never
  // exceeds T_MAX and cannot wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    rcnt_nxt  = rcnt;
    cmd_nxt   = CMD_NOP;
    addr_nxt  = ADDR_A10;
    bank_nxt  = '0;
    case (state)
      ST_PWR: begin
        if (cnt == CNT_W'(T_PWR)) begin
          cmd_nxt   = CMD_PRE;
          state_nxt = ST_PRE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_PRE: begin
        if (cnt == CNT_W'(T_RP)) begin
          cmd_nxt   = CMD_AREF;
          state_nxt = ST_REF;
          cnt_nxt   = CNT_W'(1);
          rcnt_nxt  = RC_W'(1);
        end
      end
      ST_REF: begin
        if (cnt == CNT_W'(T_RFC)) begin
          cnt_nxt = CNT_W'(1);
          if (rcnt == RC_W'(REF_CNT)) begin
            cmd_nxt   = CMD_MRS;
            addr_nxt  = MODE_EXT;
            state_nxt = ST_MRS;
          end else begin
            cmd_nxt  = CMD_AREF;
            rcnt_nxt = rcnt + 1'b1;
          end
        end
      end
      ST_MRS: begin
        if (cnt == CNT_W'(T_MRD)) begin
`ifdef SDRAM_INIT_EMRS_EN
          cmd_nxt   = CMD_MRS;
          addr_nxt  = EMODE_EXT;
          bank_nxt  = BANK_MSB;
          state_nxt = ST_EMRS;
          cnt_nxt   = CNT_W'(1);
`else
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
          rcnt_nxt  = '0;
`endif
        end
      end
`ifdef SDRAM_INIT_EMRS_EN
      ST_EMRS: begin
        if (cnt == CNT_W'(T_MRD)) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
          rcnt_nxt  = '0;
        end
      end
`endif
      ST_DONE: begin
        cnt_nxt = '0;
        // Re-init skips the power-up wait and issues PRECHARGE immediately.
        if (init_req) begin
          cmd_nxt   = CMD_PRE;
          state_nxt = ST_PRE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_PWR;
        cnt_nxt   = '0;
        rcnt_nxt  = '0;
      end
    endcase
  end

endmodule
